// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the async-FIFO read-side stream adapter.
// Holds the head/skid occupancy enum and the delivered-word counter width.
package fifo_rd_stream_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_e;

   function automatic logic [1:0] occ_count(input occ_state_e s);
      case (s)
         ONE:     return 2'd1;
         TWO:     return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/skid holding buffer between the FIFO read port and the stream.
// Head drives the stream; skid absorbs a word that lands while head is still held.
module stream_skid_buf
   import fifo_rd_stream_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap_valid,
   input  logic [DSIZE-1:0] cap_data,
   input  logic             out_ready,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   output logic             pop,
   output logic [1:0]       occ
);

   occ_state_e       state_q, state_d;
   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] skid_q, skid_d;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = head_q;
   assign pop       = out_valid && out_ready;
   assign occ       = occ_count(state_q);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (cap_valid) state_d = ONE;
         ONE: begin
            if (cap_valid && !pop)      state_d = TWO;
            else if (!cap_valid && pop) state_d = EMPTY;
         end
         TWO: if (!cap_valid && pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // A popped skid word moves up to head; a new word goes to head only if head is free after the pop.
   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      if (pop && state_q == TWO) begin
         head_d = skid_q;
         if (cap_valid) skid_d = cap_data;
      end else if (cap_valid) begin
         if (state_q == EMPTY || pop) head_d = cap_data;
         else                         skid_d = cap_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read side to valid/ready stream adapter with a head/skid buffer.
// Optional delivered-word counter on port word_cnt when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   output logic [DSIZE-1:0] m_tdata,
   output logic             m_tvalid,
   input  logic             m_tready
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [CNT_W-1:0] word_cnt
`endif
);

   logic       pend_q, pend_d;
   logic       pop;
   logic [1:0] occ;
   logic [2:0] fill_after;

   stream_skid_buf #(
      .DSIZE(DSIZE)
   ) u_buf (
      .clk       (rclk),
      .rst_n     (rrst_n),
      .cap_valid (pend_q),
      .cap_data  (rdata),
      .out_ready (m_tready),
      .out_data  (m_tdata),
      .out_valid (m_tvalid),
      .pop       (pop),
      .occ       (occ)
   );

   // Count the word already in flight so a read is only issued when a slot is guaranteed.
   always_comb begin
      fill_after = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
      rinc       = !rempty && (fill_after < 3'd2);
      pend_d     = rinc;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) pend_q <= 1'b0;
      else         pend_q <= pend_d;
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pop) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port (registered rdata).
// Counter checks are built only when FIFO_RD_STREAM_CNT_EN is defined.
module tb_fifo_rd_stream;

   localparam int DSIZE = 8;

   logic             rclk = 1'b0;
   logic             rrst_n = 1'b0;
   logic [DSIZE-1:0] rdata;
   logic             rempty;
   logic             rinc;
   logic [DSIZE-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tready = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [31:0]      word_cnt;
`endif

   logic             push_en = 1'b0;
   logic [7:0]       push_data = 8'h00;

   int chk_cnt = 0;
   int err_cnt = 0;

   always #5 rclk = ~rclk;

   fifo_rd_stream #(.DSIZE(DSIZE)) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rdata    (rdata),
      .rempty   (rempty),
      .rinc     (rinc),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready)
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .word_cnt (word_cnt)
`endif
   );

   // Behavioural FIFO: read data appears the cycle after rinc; read side flushed by rrst_n.
   logic [7:0] mem [0:127];
   logic [6:0] wr_ptr, rd_ptr;

   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         rdata  <= '0;
      end else begin
         if (rinc && (wr_ptr != rd_ptr)) begin
            rdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 7'd1;
         end
         if (push_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 7'd1;
         end
      end
   end

   assign rempty = (wr_ptr == rd_ptr);

   // Beat recorder and read-while-empty watchdog, sampled mid-cycle.
   int         cyc = 0;
   int         rx_cnt = 0;
   int         viol_cnt = 0;
   logic [7:0] rx_data [0:255];
   int         rx_cyc  [0:255];

   always @(negedge rclk) begin
      cyc++;
      if (rinc && rempty) viol_cnt++;
      if (rrst_n && m_tvalid && m_tready) begin
         rx_data[rx_cnt] = m_tdata;
         rx_cyc[rx_cnt]  = cyc;
         rx_cnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] d, input logic rdy);
      push_en   = en;
      push_data = d;
      m_tready  = rdy;
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic waitBeats(input int target, input int budget);
      for (int c = 0; c < budget && rx_cnt < target; c++) tick();
      checkOutput("beat_budget", 32'(rx_cnt >= target), 32'd1);
   endtask

   task automatic resetDut();
      rrst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
      checkOutput("rst_rinc", 32'(rinc), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("rst_cnt", word_cnt, 32'd0);
`endif
      tick();
      rrst_n = 1'b1;
      tick();
   endtask

   int base;
   int rinc_seen;
   int rinc_at;
   int valid_at;

   initial begin
      $display("[TB] start");

      // Streaming: 16 preloaded words drain back-to-back once ready rises.
      resetDut();
      base = rx_cnt;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i + 1), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitBeats(base + 16, 60);
      for (int i = 0; i < 16; i++)
         checkOutput($sformatf("stream_data%0d", i), 32'(rx_data[base + i]), 32'(i + 1));
      checkOutput("stream_consecutive", 32'(rx_cyc[base + 15] - rx_cyc[base]), 32'd15);
      checkOutput("stream_no_rinc_empty", 32'(viol_cnt), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("stream_cnt", word_cnt, 32'd16);
`endif

      // Backpressure: 10 stalled cycles allow exactly two reads, head holds 0xA0.
      resetDut();
      base = rx_cnt;
      rinc_seen = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i < 4, 8'(8'hA0 + i), 1'b0);
         @(negedge rclk);
         if (rinc) rinc_seen++;
         if (m_tvalid) checkOutput("stall_tdata", 32'(m_tdata), 32'hA0);
         tick();
      end
      checkOutput("stall_rinc_cycles", 32'(rinc_seen), 32'd2);
      checkOutput("stall_tvalid", 32'(m_tvalid), 32'd1);
      checkOutput("stall_no_beats", 32'(rx_cnt - base), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitBeats(base + 4, 40);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("stall_data%0d", i), 32'(rx_data[base + i]), 32'(8'hA0 + i));
      checkOutput("stall_no_rinc_empty", 32'(viol_cnt), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("stall_cnt", word_cnt, 32'd4);
`endif

      // Toggling ready: 8 words arrive in order with nothing extra.
      resetDut();
      base = rx_cnt;
      for (int c = 0; c < 80 && (c < 8 || rx_cnt < base + 8); c++) begin
         applyStimulus(c < 8, 8'(8'hC0 + c), (c % 2) == 0);
         @(negedge rclk);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      repeat (4) tick();
      checkOutput("toggle_count", 32'(rx_cnt - base), 32'd8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("toggle_data%0d", i), 32'(rx_data[base + i]), 32'(8'hC0 + i));
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("toggle_cnt", word_cnt, 32'd8);
`endif

      // Reset while holding two words: outputs clear at once, stale words never reappear.
      resetDut();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'(8'h90 + i), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("midrst_pre_tvalid", 32'(m_tvalid), 32'd1);
      rrst_n = 1'b0;
      #1;
      checkOutput("midrst_tvalid", 32'(m_tvalid), 32'd0);
      checkOutput("midrst_tdata", 32'(m_tdata), 32'd0);
      checkOutput("midrst_rinc", 32'(rinc), 32'd0);
      tick();
      tick();
      rrst_n = 1'b1;
      tick();
      base = rx_cnt;
      applyStimulus(1'b1, 8'h77, 1'b1);
      tick();
      applyStimulus(1'b1, 8'h78, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitBeats(base + 2, 20);
      checkOutput("midrst_first", 32'(rx_data[base]), 32'h77);
      checkOutput("midrst_second", 32'(rx_data[base + 1]), 32'h78);

      // Empty wrap: gap with no valid, then a fresh word with two-cycle latency from rinc.
      resetDut();
      base = rx_cnt;
      applyStimulus(1'b1, 8'h5A, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitBeats(base + 1, 20);
      for (int g = 0; g < 5; g++) begin
         @(negedge rclk);
         checkOutput("wrap_gap_tvalid", 32'(m_tvalid), 32'd0);
         tick();
      end
      rinc_at  = -1;
      valid_at = -1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i == 0, 8'h5B, 1'b1);
         @(negedge rclk);
         if (rinc && rinc_at < 0) rinc_at = i;
         if (m_tvalid && valid_at < 0) valid_at = i;
         tick();
      end
      checkOutput("wrap_rinc_at", 32'(rinc_at), 32'd1);
      checkOutput("wrap_latency", 32'(valid_at - rinc_at), 32'd2);
      checkOutput("wrap_count", 32'(rx_cnt - base), 32'd2);
      checkOutput("wrap_first", 32'(rx_data[base]), 32'h5A);
      checkOutput("wrap_second", 32'(rx_data[base + 1]), 32'h5B);
`ifdef FIFO_RD_STREAM_CNT_EN
      checkOutput("wrap_cnt", word_cnt, 32'd2);

      // Counter wraps from all-ones to zero on one pop.
      resetDut();
      applyStimulus(1'b1, 8'h42, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      repeat (3) tick();
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      checkOutput("cnt_forced", word_cnt, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 8'h00, 1'b1);
      @(negedge rclk);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("cnt_wrap", word_cnt, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
